accum_calc: RTL and testbench



---
 rtl/accum_calc.sv | 120 ++++++++++++
 tb/tb_accum_calc.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_calc.sv
// accum_calc: four debounced pushbuttons drive load/add/subtract/show operations on a WIDTH-bit accumulator.
// Optional build macro ACCUM_SAT_EN makes ADD/SUB saturate instead of wrapping modulo 2**WIDTH.
module accum_calc #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 17
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] sw,
  input  logic [3:0]       btn,
  output logic [WIDTH-1:0] disp_value,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             zero,
  output logic             show_acc
);

  localparam int BTN_STORE = 0;
  localparam int BTN_ADD   = 1;
  localparam int BTN_SHOW  = 2;
  localparam int BTN_SUB   = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0] s1;
  logic [3:0] s2;
  logic [3:0] press;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_btn
      logic [CNT_W-1:0] cnt;
      logic             db;
      logic             db_prev;

      always_ff @(posedge CLK) begin
        if (RST) begin
          cnt     <= '0;
          db      <= 1'b0;
          db_prev <= 1'b0;
        end else begin
          db_prev <= db;
          if (s2[i] == db) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            db  <= s2[i];
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign press[i] = db & ~db_prev;
    end
  endgenerate

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] acc_next;
  logic             carry_next;

  assign sum    = {1'b0, acc} + {1'b0, sw};
  assign diff   = acc - sw;
  assign borrow = (sw > acc);

  // Only one arithmetic press wins per cycle: STORE > SUB > ADD.
  always_comb begin
    acc_next   = acc;
    carry_next = carry;
    if (press[BTN_STORE]) begin
      acc_next   = sw;
      carry_next = 1'b0;
    end else if (press[BTN_SUB]) begin
`ifdef ACCUM_SAT_EN
      acc_next   = borrow ? '0 : diff;
`else
      acc_next   = diff;
`endif
      carry_next = borrow;
    end else if (press[BTN_ADD]) begin
`ifdef ACCUM_SAT_EN
      acc_next   = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
      acc_next   = sum[WIDTH-1:0];
`endif
      carry_next = sum[WIDTH];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc      <= '0;
      carry    <= 1'b0;
      zero     <= 1'b1;
      show_acc <= 1'b0;
    end else begin
      acc      <= acc_next;
      carry    <= carry_next;
      zero     <= (acc_next == '0);
      show_acc <= show_acc ^ press[BTN_SHOW];
    end
  end

  assign disp_value = show_acc ? acc : sw;

endmodule

// File: tb/tb_accum_calc.sv
// Self-checking bench for accum_calc: directed scenarios plus randomized presses against an arithmetic model.
// Honours ACCUM_SAT_EN so the same bench checks either build.
module tb_accum_calc;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] sw;
  logic [3:0]   btn;
  logic [W-1:0] disp_value;
  logic [W-1:0] acc;
  logic         carry;
  logic         zero;
  logic         show_acc;

  int vectors     = 0;
  int miscompares = 0;

  int m_acc;
  bit m_carry;
  bit m_show;

  accum_calc #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(17)) dut (
    .CLK(CLK),
    .RST(RST),
    .sw(sw),
    .btn(btn),
    .disp_value(disp_value),
    .acc(acc),
    .carry(carry),
    .zero(zero),
    .show_acc(show_acc)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic model_reset();
    m_acc   = 0;
    m_carry = 1'b0;
    m_show  = 1'b0;
  endtask

  // Plain-arithmetic view of one accepted press set.
  task automatic model_press(input logic [3:0] mask, input logic [W-1:0] s);
    int v;
    v = int'(s);
    if (mask[0]) begin
      m_acc   = v;
      m_carry = 1'b0;
    end else if (mask[3]) begin
      m_carry = (v > m_acc);
      if (!m_carry) m_acc = m_acc - v;
`ifdef ACCUM_SAT_EN
      else m_acc = 0;
`else
      else m_acc = m_acc - v + MAXV + 1;
`endif
    end else if (mask[1]) begin
      m_carry = (m_acc + v > MAXV);
      if (!m_carry) m_acc = m_acc + v;
`ifdef ACCUM_SAT_EN
      else m_acc = MAXV;
`else
      else m_acc = m_acc + v - (MAXV + 1);
`endif
    end
    if (mask[2]) m_show = ~m_show;
  endtask

  // Press lands on the edge D+3 after the level is applied.
  task automatic do_press(input logic [3:0] mask);
    btn = mask;
    tick(D + 3);
    model_press(mask, sw);
  endtask

  task automatic do_release();
    btn = 4'b0000;
    tick(D + 3);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    btn = 4'b0000;
    sw  = 8'h5A;
    tick(2);
    model_reset();
    vectors++; if (acc !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_acc: got %h expected %h", acc, 8'h00); end
    vectors++; if (carry !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_carry: got %b expected 0", carry); end
    vectors++; if (zero !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_zero: got %b expected 1", zero); end
    vectors++; if (show_acc !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_show: got %b expected 0", show_acc); end
    vectors++; if (disp_value !== 8'h5A) begin miscompares++; $display("[TB] FAIL reset_disp: got %h expected %h", disp_value, 8'h5A); end
    RST = 1'b0;
    tick(2);
    vectors++; if (acc !== 8'h00) begin miscompares++; $display("[TB] FAIL idle_acc: got %h expected %h", acc, 8'h00); end
  endtask

  task automatic test_store_latency();
    sw  = 8'h3C;
    btn = 4'b0001;
    tick(D + 2);
    vectors++; if (acc !== 8'h00) begin miscompares++; $display("[TB] FAIL store_early: got %h expected %h", acc, 8'h00); end
    tick(1);
    model_press(4'b0001, sw);
    vectors++; if (acc !== 8'h3C) begin miscompares++; $display("[TB] FAIL store_acc: got %h expected %h", acc, 8'h3C); end
    vectors++; if (carry !== 1'b0) begin miscompares++; $display("[TB] FAIL store_carry: got %b expected 0", carry); end
    vectors++; if (zero !== 1'b0) begin miscompares++; $display("[TB] FAIL store_zero: got %b expected 0", zero); end
    sw = 8'hA5;
    tick(10);
    vectors++; if (acc !== 8'h3C) begin miscompares++; $display("[TB] FAIL store_single: got %h expected %h", acc, 8'h3C); end
    do_release();
  endtask

  task automatic test_add_wrap();
    logic [W-1:0] exp_acc;
`ifdef ACCUM_SAT_EN
    exp_acc = 8'hFF;
`else
    exp_acc = 8'h10;
`endif
    sw = 8'hF0;
    do_press(4'b0001);
    do_release();
    sw = 8'h20;
    do_press(4'b0010);
    vectors++; if (acc !== exp_acc) begin miscompares++; $display("[TB] FAIL add_wrap_acc: got %h expected %h", acc, exp_acc); end
    vectors++; if (carry !== 1'b1) begin miscompares++; $display("[TB] FAIL add_wrap_carry: got %b expected 1", carry); end
    vectors++; if (zero !== 1'b0) begin miscompares++; $display("[TB] FAIL add_wrap_zero: got %b expected 0", zero); end
    do_release();
  endtask

  task automatic test_sub();
    logic [W-1:0] exp_acc;
    logic         exp_zero;
`ifdef ACCUM_SAT_EN
    exp_acc  = 8'h00;
    exp_zero = 1'b1;
`else
    exp_acc  = 8'hFF;
    exp_zero = 1'b0;
`endif
    sw = 8'h05;
    do_press(4'b0001);
    do_release();
    do_press(4'b1000);
    vectors++; if (acc !== 8'h00) begin miscompares++; $display("[TB] FAIL sub_exact_acc: got %h expected %h", acc, 8'h00); end
    vectors++; if (zero !== 1'b1) begin miscompares++; $display("[TB] FAIL sub_exact_zero: got %b expected 1", zero); end
    vectors++; if (carry !== 1'b0) begin miscompares++; $display("[TB] FAIL sub_exact_carry: got %b expected 0", carry); end
    do_release();
    sw = 8'h01;
    do_press(4'b1000);
    vectors++; if (acc !== exp_acc) begin miscompares++; $display("[TB] FAIL sub_borrow_acc: got %h expected %h", acc, exp_acc); end
    vectors++; if (carry !== 1'b1) begin miscompares++; $display("[TB] FAIL sub_borrow_carry: got %b expected 1", carry); end
    vectors++; if (zero !== exp_zero) begin miscompares++; $display("[TB] FAIL sub_borrow_zero: got %b expected %b", zero, exp_zero); end
    do_release();
  endtask

  task automatic test_bounce();
    logic [W-1:0] s;
    sw = 8'h40;
    do_press(4'b0001);
    do_release();
    s  = W'($urandom_range(1, 63));
    sw = s;
    for (int k = 0; k < 10; k++) begin
      btn = (k % 2 == 0) ? 4'b0010 : 4'b0000;
      tick(2);
    end
    vectors++; if (acc !== 8'h40) begin miscompares++; $display("[TB] FAIL bounce_ignored: got %h expected %h", acc, 8'h40); end
    btn = 4'b0010;
    tick(D + 3 + 20);
    model_press(4'b0010, s);
    vectors++; if (acc !== 8'(8'h40 + s)) begin miscompares++; $display("[TB] FAIL bounce_single_add: got %h expected %h", acc, 8'(8'h40 + s)); end
    vectors++; if (acc !== m_acc[W-1:0]) begin miscompares++; $display("[TB] FAIL bounce_model: got %h expected %h", acc, m_acc[W-1:0]); end
    do_release();
  endtask

  task automatic test_simultaneous();
    sw = 8'h10;
    do_press(4'b0001);
    do_release();
    sw = 8'h04;
    do_press(4'b1101);
    vectors++; if (acc !== 8'h04) begin miscompares++; $display("[TB] FAIL simul_acc: got %h expected %h", acc, 8'h04); end
    vectors++; if (carry !== 1'b0) begin miscompares++; $display("[TB] FAIL simul_carry: got %b expected 0", carry); end
    vectors++; if (show_acc !== 1'b1) begin miscompares++; $display("[TB] FAIL simul_show: got %b expected 1", show_acc); end
    vectors++; if (disp_value !== 8'h04) begin miscompares++; $display("[TB] FAIL simul_disp: got %h expected %h", disp_value, 8'h04); end
    do_release();
    sw = 8'h77;
    #1;
    vectors++; if (disp_value !== 8'h04) begin miscompares++; $display("[TB] FAIL show_mode_disp: got %h expected %h", disp_value, 8'h04); end
    do_press(4'b0100);
    do_release();
    vectors++; if (show_acc !== 1'b0) begin miscompares++; $display("[TB] FAIL show_back: got %b expected 0", show_acc); end
    vectors++; if (disp_value !== 8'h77) begin miscompares++; $display("[TB] FAIL live_disp: got %h expected %h", disp_value, 8'h77); end
  endtask

  task automatic test_random();
    logic [3:0]   mask;
    logic [W-1:0] exp_disp;
    for (int n = 0; n < 40; n++) begin
      sw   = W'($urandom);
      mask = 4'($urandom_range(1, 15));
      do_press(mask);
      exp_disp = m_show ? m_acc[W-1:0] : sw;
      vectors++; if (acc !== m_acc[W-1:0]) begin miscompares++; $display("[TB] FAIL rand_acc[%0d] mask %b: got %h expected %h", n, mask, acc, m_acc[W-1:0]); end
      vectors++; if (carry !== m_carry) begin miscompares++; $display("[TB] FAIL rand_carry[%0d] mask %b: got %b expected %b", n, mask, carry, m_carry); end
      vectors++; if (zero !== (m_acc == 0)) begin miscompares++; $display("[TB] FAIL rand_zero[%0d]: got %b expected %b", n, zero, (m_acc == 0)); end
      vectors++; if (show_acc !== m_show) begin miscompares++; $display("[TB] FAIL rand_show[%0d]: got %b expected %b", n, show_acc, m_show); end
      vectors++; if (disp_value !== exp_disp) begin miscompares++; $display("[TB] FAIL rand_disp[%0d]: got %h expected %h", n, disp_value, exp_disp); end
      do_release();
      vectors++; if (acc !== m_acc[W-1:0]) begin miscompares++; $display("[TB] FAIL rand_release[%0d]: got %h expected %h", n, acc, m_acc[W-1:0]); end
    end
  endtask

  task automatic test_reset_mid_debounce();
    sw  = 8'hC3;
    btn = 4'b0100;
    tick(3);
    RST = 1'b1;
    tick(1);
    model_reset();
    RST = 1'b0;
    vectors++; if (acc !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_mid_acc: got %h expected %h", acc, 8'h00); end
    vectors++; if (carry !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_carry: got %b expected 0", carry); end
    vectors++; if (zero !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_mid_zero: got %b expected 1", zero); end
    vectors++; if (show_acc !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_show: got %b expected 0", show_acc); end
    vectors++; if (disp_value !== 8'hC3) begin miscompares++; $display("[TB] FAIL rst_mid_disp: got %h expected %h", disp_value, 8'hC3); end
    tick(D + 2);
    vectors++; if (show_acc !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_redebounce_early: got %b expected 0", show_acc); end
    tick(1);
    model_press(4'b0100, sw);
    vectors++; if (show_acc !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_redebounce_show: got %b expected 1", show_acc); end
    vectors++; if (disp_value !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_redebounce_disp: got %h expected %h", disp_value, 8'h00); end
    do_release();
  endtask

  initial begin
    RST = 1'b1;
    btn = 4'b0000;
    sw  = '0;
    model_reset();
    test_reset();
    test_store_latency();
    test_add_wrap();
    test_sub();
    test_bounce();
    test_simultaneous();
    test_random();
    test_reset_mid_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
